// File: rtl/axi_wr_arbiter_pkg.sv
// Shared types and constants for the two-master AXI write arbiter.
//   arb_state_e : write-path FSM states
//   m_idx_t     : master index (also the slave-side ID prefix bit)
//   aw_ctl_t    : registered AW burst-control fields
package axi_arb_pkg;

    localparam int unsigned NUM_M   = 2;
    localparam int unsigned LEN_W   = 4;
    localparam int unsigned SIZE_W  = 3;
    localparam int unsigned BURST_W = 2;
    localparam int unsigned RESP_W  = 2;

    localparam logic [RESP_W-1:0] BRESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] BRESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AW   = 2'd1,
        W    = 2'd2
    } arb_state_e;

    typedef logic m_idx_t;

    typedef struct packed {
        logic [LEN_W-1:0]   len;
        logic [SIZE_W-1:0]  size;
        logic [BURST_W-1:0] burst;
    } aw_ctl_t;

endpackage

// File: rtl/axi_wr_arbiter_rr_arb.sv
// Two-requester grant selection for the AXI write arbiter.
// Build option: AXI_ARB_RR_EN selects round-robin (last_grant register);
// without it master 0 has fixed priority and the block is purely combinational.
// Ports:
//   clk_i, rst_ni : clock / async active-low reset (round-robin build only)
//   take_i        : a grant is being accepted this cycle (round-robin build only)
//   req_i         : per-master request
//   gnt_o         : index of the winning master (valid when any req_i is set)
module axi_rr_arb
    import axi_arb_pkg::*;
(
`ifdef AXI_ARB_RR_EN
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             take_i,
`endif
    input  logic [NUM_M-1:0] req_i,
    output m_idx_t           gnt_o
);

`ifdef AXI_ARB_RR_EN
    m_idx_t last_grant_q;

    // On contention the master that did not win last time is chosen.
    always_comb begin
        gnt_o = 1'b0;
        if (req_i[0] && req_i[1]) begin
            gnt_o = ~last_grant_q;
        end else if (req_i[1]) begin
            gnt_o = 1'b1;
        end
    end

    // Reset to master 1 so that master 0 wins the first contention.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_grant_q <= 1'b1;
        end else if (take_i) begin
            last_grant_q <= gnt_o;
        end
    end
`else
    // Fixed priority: master 1 only wins when master 0 is not requesting.
    assign gnt_o = ~req_i[0] & req_i[1];
`endif

endmodule

// File: rtl/axi_wr_arbiter.sv
// Two-master to one-slave AXI write-path arbiter (AW, W, B channels).
// One burst at a time: the winning AW is registered and presented to the
// slave, then W is locked to the granted master until its wlast beat.
// B responses are routed by the top slave-ID bit, independent of the FSM.
// Build option: AXI_ARB_RR_EN enables round-robin arbitration (default: fixed
// priority, master 0 first).
// Ports:
//   aclk, arst          : clock, async active-low reset
//   mX_aw*              : master AW channels (mX_awready driven in IDLE only)
//   mX_w*               : master W channels (wready only to the granted master)
//   mX_b*               : master B channels (routed from s_b*)
//   s_aw*               : registered slave AW channel, s_awid = {grant, awid}
//   s_w*                : slave W channel, combinational from the granted master
//   s_b*                : slave B channel
//   wlast_err           : sticky flag for a wlast/awlen disagreement
module axi_wr_arbiter
    import axi_arb_pkg::*;
#(
    parameter int unsigned ID_W   = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                  aclk,
    input  logic                  arst,

    input  logic [ID_W-1:0]       m0_awid,
    input  logic [ADDR_W-1:0]     m0_awaddr,
    input  logic [LEN_W-1:0]      m0_awlen,
    input  logic [SIZE_W-1:0]     m0_awsize,
    input  logic [BURST_W-1:0]    m0_awburst,
    input  logic                  m0_awvalid,
    output logic                  m0_awready,
    input  logic [DATA_W-1:0]     m0_wdata,
    input  logic [DATA_W/8-1:0]   m0_wstrb,
    input  logic                  m0_wlast,
    input  logic                  m0_wvalid,
    output logic                  m0_wready,
    output logic [ID_W-1:0]       m0_bid,
    output logic [RESP_W-1:0]     m0_bresp,
    output logic                  m0_bvalid,
    input  logic                  m0_bready,

    input  logic [ID_W-1:0]       m1_awid,
    input  logic [ADDR_W-1:0]     m1_awaddr,
    input  logic [LEN_W-1:0]      m1_awlen,
    input  logic [SIZE_W-1:0]     m1_awsize,
    input  logic [BURST_W-1:0]    m1_awburst,
    input  logic                  m1_awvalid,
    output logic                  m1_awready,
    input  logic [DATA_W-1:0]     m1_wdata,
    input  logic [DATA_W/8-1:0]   m1_wstrb,
    input  logic                  m1_wlast,
    input  logic                  m1_wvalid,
    output logic                  m1_wready,
    output logic [ID_W-1:0]       m1_bid,
    output logic [RESP_W-1:0]     m1_bresp,
    output logic                  m1_bvalid,
    input  logic                  m1_bready,

    output logic [ID_W:0]         s_awid,
    output logic [ADDR_W-1:0]     s_awaddr,
    output logic [LEN_W-1:0]      s_awlen,
    output logic [SIZE_W-1:0]     s_awsize,
    output logic [BURST_W-1:0]    s_awburst,
    output logic                  s_awvalid,
    input  logic                  s_awready,
    output logic [DATA_W-1:0]     s_wdata,
    output logic [DATA_W/8-1:0]   s_wstrb,
    output logic                  s_wlast,
    output logic                  s_wvalid,
    input  logic                  s_wready,
    input  logic [ID_W:0]         s_bid,
    input  logic [RESP_W-1:0]     s_bresp,
    input  logic                  s_bvalid,
    output logic                  s_bready,

    output logic                  wlast_err
);

    arb_state_e         state_q;
    m_idx_t             grant_idx_q;
    logic [ID_W:0]      s_awid_q;
    logic [ADDR_W-1:0]  s_awaddr_q;
    aw_ctl_t            aw_ctl_q;
    logic               s_awvalid_q;
    logic [LEN_W-1:0]   beat_cnt_q;
    logic               wlast_err_q;

    m_idx_t             gnt;
    logic               grant_fire;
    logic [ID_W-1:0]    sel_awid;
    logic [ADDR_W-1:0]  sel_awaddr;
    aw_ctl_t            sel_ctl;
    logic               in_w;
    logic               w_hs;
    logic               bsel;

    // Arbitration among pending AW requests.
    axi_rr_arb u_arb (
`ifdef AXI_ARB_RR_EN
        .clk_i  (aclk),
        .rst_ni (arst),
        .take_i (grant_fire),
`endif
        .req_i  ({m1_awvalid, m0_awvalid}),
        .gnt_o  (gnt)
    );

    // AW accept happens in IDLE in the same cycle the request is seen.
    assign grant_fire = (state_q == IDLE) && (m0_awvalid || m1_awvalid);
    assign m0_awready = grant_fire && (gnt == 1'b0);
    assign m1_awready = grant_fire && (gnt == 1'b1);

    assign sel_awid   = gnt ? m1_awid   : m0_awid;
    assign sel_awaddr = gnt ? m1_awaddr : m0_awaddr;
    assign sel_ctl    = gnt ? aw_ctl_t'({m1_awlen, m1_awsize, m1_awburst})
                            : aw_ctl_t'({m0_awlen, m0_awsize, m0_awburst});

    // W channel: pass-through from the granted master while in W only.
    assign in_w      = (state_q == W);
    assign s_wdata   = grant_idx_q ? m1_wdata  : m0_wdata;
    assign s_wstrb   = grant_idx_q ? m1_wstrb  : m0_wstrb;
    assign s_wlast   = grant_idx_q ? m1_wlast  : m0_wlast;
    assign s_wvalid  = in_w && (grant_idx_q ? m1_wvalid : m0_wvalid);
    assign m0_wready = in_w && !grant_idx_q && s_wready;
    assign m1_wready = in_w &&  grant_idx_q && s_wready;
    assign w_hs      = s_wvalid && s_wready;

    // Write FSM, registered AW payload, beat counter and error flag.
    always_ff @(posedge aclk or negedge arst) begin
        if (!arst) begin
            state_q     <= IDLE;
            grant_idx_q <= 1'b0;
            s_awid_q    <= '0;
            s_awaddr_q  <= '0;
            aw_ctl_q    <= '0;
            s_awvalid_q <= 1'b0;
            beat_cnt_q  <= '0;
            wlast_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_fire) begin
                        grant_idx_q <= gnt;
                        s_awid_q    <= {gnt, sel_awid};
                        s_awaddr_q  <= sel_awaddr;
                        aw_ctl_q    <= sel_ctl;
                        s_awvalid_q <= 1'b1;
                        state_q     <= AW;
                    end
                end
                AW: begin
                    if (s_awready) begin
                        s_awvalid_q <= 1'b0;
                        beat_cnt_q  <= '0;
                        state_q     <= W;
                    end
                end
                W: begin
                    if (w_hs) begin
                        beat_cnt_q <= beat_cnt_q + LEN_W'(1);
                        // Either side of the wlast/awlen agreement can be broken.
                        if (s_wlast != (beat_cnt_q == aw_ctl_q.len)) begin
                            wlast_err_q <= 1'b1;
                        end
                        // Only wlast ends the burst, even when it disagrees with awlen.
                        if (s_wlast) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign s_awid    = s_awid_q;
    assign s_awaddr  = s_awaddr_q;
    assign s_awlen   = aw_ctl_q.len;
    assign s_awsize  = aw_ctl_q.size;
    assign s_awburst = aw_ctl_q.burst;
    assign s_awvalid = s_awvalid_q;
    assign wlast_err = wlast_err_q;

    // B routing: the ID prefix bit picks the destination master.
    assign bsel      = s_bid[ID_W];
    assign m0_bid    = s_bid[ID_W-1:0];
    assign m1_bid    = s_bid[ID_W-1:0];
    assign m0_bresp  = s_bresp;
    assign m1_bresp  = s_bresp;
    assign m0_bvalid = s_bvalid && !bsel;
    assign m1_bvalid = s_bvalid &&  bsel;
    assign s_bready  = bsel ? m1_bready : m0_bready;

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed testbench for axi_wr_arbiter: single burst, arbitration order,
// B routing, early W data, wlast errors and reset in the middle of a burst.
module tb_axi_wr_arbiter;
    import axi_arb_pkg::*;

    localparam int unsigned ID_W   = 4;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    logic aclk = 1'b0;
    logic arst;

    logic [ID_W-1:0]   m0_awid, m1_awid;
    logic [ADDR_W-1:0] m0_awaddr, m1_awaddr;
    logic [3:0]        m0_awlen, m1_awlen;
    logic [2:0]        m0_awsize, m1_awsize;
    logic [1:0]        m0_awburst, m1_awburst;
    logic              m0_awvalid, m1_awvalid, m0_awready, m1_awready;
    logic [DATA_W-1:0] m0_wdata, m1_wdata;
    logic [STRB_W-1:0] m0_wstrb, m1_wstrb;
    logic              m0_wlast, m1_wlast, m0_wvalid, m1_wvalid, m0_wready, m1_wready;
    logic [ID_W-1:0]   m0_bid, m1_bid;
    logic [1:0]        m0_bresp, m1_bresp;
    logic              m0_bvalid, m1_bvalid, m0_bready, m1_bready;
    logic [ID_W:0]     s_awid;
    logic [ADDR_W-1:0] s_awaddr;
    logic [3:0]        s_awlen;
    logic [2:0]        s_awsize;
    logic [1:0]        s_awburst;
    logic              s_awvalid, s_awready;
    logic [DATA_W-1:0] s_wdata;
    logic [STRB_W-1:0] s_wstrb;
    logic              s_wlast, s_wvalid, s_wready;
    logic [ID_W:0]     s_bid;
    logic [1:0]        s_bresp;
    logic              s_bvalid, s_bready;
    logic              wlast_err;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    axi_wr_arbiter #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .aclk(aclk), .arst(arst),
        .m0_awid(m0_awid), .m0_awaddr(m0_awaddr), .m0_awlen(m0_awlen),
        .m0_awsize(m0_awsize), .m0_awburst(m0_awburst),
        .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wlast(m0_wlast),
        .m0_wvalid(m0_wvalid), .m0_wready(m0_wready),
        .m0_bid(m0_bid), .m0_bresp(m0_bresp), .m0_bvalid(m0_bvalid), .m0_bready(m0_bready),
        .m1_awid(m1_awid), .m1_awaddr(m1_awaddr), .m1_awlen(m1_awlen),
        .m1_awsize(m1_awsize), .m1_awburst(m1_awburst),
        .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wlast(m1_wlast),
        .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
        .m1_bid(m1_bid), .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
        .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
        .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .wlast_err(wlast_err)
    );

    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_aw(input int m, input logic [3:0] id, input logic [31:0] addr,
                          input logic [3:0] len, input logic v);
        if (m == 0) begin
            m0_awid = id; m0_awaddr = addr; m0_awlen = len;
            m0_awsize = 3'd2; m0_awburst = 2'd1; m0_awvalid = v;
        end else begin
            m1_awid = id; m1_awaddr = addr; m1_awlen = len;
            m1_awsize = 3'd2; m1_awburst = 2'd1; m1_awvalid = v;
        end
    endtask

    task automatic set_w(input int m, input logic [31:0] data, input logic last, input logic v);
        if (m == 0) begin
            m0_wdata = data; m0_wstrb = '1; m0_wlast = last; m0_wvalid = v;
        end else begin
            m1_wdata = data; m1_wstrb = '1; m1_wlast = last; m1_wvalid = v;
        end
    endtask

    // Request, accept, check the registered AW, then complete the slave handshake.
    task automatic aw_through(input int m, input logic [3:0] id, input logic [31:0] addr,
                              input logic [3:0] len);
        set_aw(m, id, addr, len, 1'b1);
        settle();
        chk("aw_awready", (m == 0) ? m0_awready : m1_awready, 1);
        tick();
        set_aw(m, id, addr, len, 1'b0);
        settle();
        chk("aw_s_awvalid", s_awvalid, 1);
        chk("aw_s_awid", s_awid, {m[0], id});
        chk("aw_s_awaddr", s_awaddr, addr);
        chk("aw_s_awlen", s_awlen, len);
        s_awready = 1'b1;
        tick();
        s_awready = 1'b0;
    endtask

    // One accepted W beat from master m.
    task automatic beat(input int m, input logic [31:0] data, input logic last);
        set_w(m, data, last, 1'b1);
        s_wready = 1'b1;
        settle();
        chk("w_s_wvalid", s_wvalid, 1);
        chk("w_s_wdata", s_wdata, data);
        chk("w_s_wlast", s_wlast, last);
        chk("w_wready", (m == 0) ? m0_wready : m1_wready, 1);
        chk("w_other_wready", (m == 0) ? m1_wready : m0_wready, 0);
        tick();
        set_w(m, 32'h0, 1'b0, 1'b0);
        s_wready = 1'b0;
    endtask

    initial begin
        arst = 1'b0;
        set_aw(0, 4'h0, 32'h0, 4'h0, 1'b0);
        set_aw(1, 4'h0, 32'h0, 4'h0, 1'b0);
        set_w(0, 32'h0, 1'b0, 1'b0);
        set_w(1, 32'h0, 1'b0, 1'b0);
        m0_bready = 1'b0; m1_bready = 1'b0;
        s_awready = 1'b0; s_wready = 1'b0;
        s_bid = '0; s_bresp = '0; s_bvalid = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_m0_awready", m0_awready, 0);
        chk("rst_m1_awready", m1_awready, 0);
        chk("rst_m0_wready", m0_wready, 0);
        chk("rst_m0_bvalid", m0_bvalid, 0);
        chk("rst_s_awvalid", s_awvalid, 0);
        chk("rst_s_wvalid", s_wvalid, 0);
        chk("rst_s_awaddr", s_awaddr, 0);
        chk("rst_s_awid", s_awid, 0);
        chk("rst_wlast_err", wlast_err, 0);
        arst = 1'b1;
        tick();

        // Single m0 burst: id=3 addr=0x100 len=3
        set_aw(0, 4'h3, 32'h100, 4'h3, 1'b1);
        settle();
        chk("t1_m0_awready", m0_awready, 1);
        chk("t1_m1_awready", m1_awready, 0);
        chk("t1_s_awvalid_n", s_awvalid, 0);
        tick();
        set_aw(0, 4'h3, 32'h100, 4'h3, 1'b0);
        settle();
        chk("t1_s_awvalid", s_awvalid, 1);
        chk("t1_s_awid", s_awid, 5'h03);
        chk("t1_s_awaddr", s_awaddr, 32'h100);
        chk("t1_s_awlen", s_awlen, 3);
        chk("t1_s_awsize", s_awsize, 2);
        chk("t1_s_awburst", s_awburst, 1);
        set_w(0, 32'hA0, 1'b0, 1'b1);
        s_wready = 1'b1;
        settle();
        chk("t1_early_wready", m0_wready, 0);
        chk("t1_early_s_wvalid", s_wvalid, 0);
        s_wready = 1'b0;
        tick();
        chk("t1_hold_awvalid", s_awvalid, 1);
        chk("t1_hold_awaddr", s_awaddr, 32'h100);
        s_awready = 1'b1;
        tick();
        s_awready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            beat(0, 32'hA0 + 32'(i), (i == 3));
        end
        chk("t1_wlast_err", wlast_err, 0);
        set_aw(0, 4'h3, 32'h100, 4'h3, 1'b1);
        settle();
        chk("t1_back_idle", m0_awready, 1);
        set_aw(0, 4'h3, 32'h100, 4'h3, 1'b0);

        // Reset so arbitration history starts fresh
        arst = 1'b0;
        tick();
        arst = 1'b1;
        tick();

        // Simultaneous requests
        for (int g = 0; g < 4; g++) begin
            logic exp_m;
            logic m0v;
`ifdef AXI_ARB_RR_EN
            exp_m = g[0];
            m0v   = 1'b1;
`else
            exp_m = (g >= 2);
            m0v   = (g < 2);
`endif
            set_aw(0, 4'h1, 32'h200, 4'h0, m0v);
            set_aw(1, 4'h2, 32'h300, 4'h0, 1'b1);
            settle();
            chk("arb_m0_awready", m0_awready, !exp_m);
            chk("arb_m1_awready", m1_awready, exp_m);
            tick();
            m0_awvalid = 1'b0;
            m1_awvalid = 1'b0;
            settle();
            chk("arb_s_awid", s_awid, exp_m ? 64'h12 : 64'h01);
            s_awready = 1'b1;
            tick();
            s_awready = 1'b0;
            beat(int'(exp_m), 32'hC0 + 32'(g), 1'b1);
        end

        // Early W data from m1 while m0 owns W; B routed during the burst
        aw_through(0, 4'h6, 32'h400, 4'h1);
        set_aw(1, 4'h9, 32'h500, 4'h0, 1'b1);
        set_w(1, 32'hBEEF, 1'b1, 1'b1);
        set_w(0, 32'h11, 1'b0, 1'b1);
        settle();
        chk("ew_m1_wready", m1_wready, 0);
        chk("ew_m1_awready", m1_awready, 0);
        chk("ew_s_wdata", s_wdata, 32'h11);
        s_bid = 5'h15; s_bresp = BRESP_SLVERR; s_bvalid = 1'b1;
        m1_bready = 1'b1; m0_bready = 1'b0;
        settle();
        chk("b_m1_bvalid", m1_bvalid, 1);
        chk("b_m1_bid", m1_bid, 5);
        chk("b_m1_bresp", m1_bresp, 2);
        chk("b_m0_bvalid", m0_bvalid, 0);
        chk("b_s_bready_hi", s_bready, 1);
        m1_bready = 1'b0;
        settle();
        chk("b_s_bready_lo", s_bready, 0);
        s_bid = 5'h07; s_bresp = 2'b00; m0_bready = 1'b1;
        settle();
        chk("b_m0_bvalid", m0_bvalid, 1);
        chk("b_m0_bid", m0_bid, 7);
        chk("b_m1_bvalid_lo", m1_bvalid, 0);
        chk("b_s_bready_m0", s_bready, 1);
        s_bvalid = 1'b0; m0_bready = 1'b0;
        tick();
        beat(0, 32'h11, 1'b0);
        set_w(0, 32'h12, 1'b1, 1'b1);
        s_wready = 1'b1;
        settle();
        chk("ew_m1_wready_b1", m1_wready, 0);
        chk("ew_m0_wready_b1", m0_wready, 1);
        tick();
        set_w(0, 32'h0, 1'b0, 1'b0);
        settle();
        chk("ew_m1_awready_idle", m1_awready, 1);
        chk("ew_m1_wready_idle", m1_wready, 0);
        tick();
        m1_awvalid = 1'b0;
        settle();
        chk("ew_m1_wready_aw", m1_wready, 0);
        chk("ew_s_awid", s_awid, 5'h19);
        s_awready = 1'b1;
        tick();
        s_awready = 1'b0;
        chk("ew_m1_wready_w", m1_wready, 1);
        chk("ew_s_wdata_m1", s_wdata, 32'hBEEF);
        chk("ew_s_wlast_m1", s_wlast, 1);
        tick();
        set_w(1, 32'h0, 1'b0, 1'b0);
        s_wready = 1'b0;
        chk("ew_wlast_err", wlast_err, 0);

        // Early wlast: len=3, wlast on beat 1
        aw_through(0, 4'h2, 32'h600, 4'h3);
        beat(0, 32'h21, 1'b0);
        chk("el_err_before", wlast_err, 0);
        beat(0, 32'h22, 1'b1);
        chk("el_err_set", wlast_err, 1);
        aw_through(0, 4'h2, 32'h700, 4'h0);
        beat(0, 32'h23, 1'b1);
        chk("el_err_sticky", wlast_err, 1);
        arst = 1'b0;
        settle();
        chk("el_err_rst", wlast_err, 0);
        tick();
        arst = 1'b1;
        tick();

        // Missing wlast at beat 3 of len=3; burst ends on a later wlast
        aw_through(0, 4'h3, 32'h800, 4'h3);
        for (int i = 0; i < 3; i++) begin
            beat(0, 32'h30 + 32'(i), 1'b0);
        end
        chk("ml_err_before", wlast_err, 0);
        beat(0, 32'h33, 1'b0);
        chk("ml_err_set", wlast_err, 1);
        beat(0, 32'h34, 1'b1);
        chk("ml_err_hold", wlast_err, 1);

        // Reset during beat 2 of len=7
        arst = 1'b0;
        tick();
        arst = 1'b1;
        tick();
        aw_through(0, 4'h4, 32'h900, 4'h7);
        beat(0, 32'h50, 1'b0);
        beat(0, 32'h51, 1'b0);
        set_w(0, 32'h52, 1'b0, 1'b1);
        s_wready = 1'b1;
        settle();
        chk("rm_s_wvalid_pre", s_wvalid, 1);
        arst = 1'b0;
        settle();
        chk("rm_s_wvalid", s_wvalid, 0);
        chk("rm_s_awvalid", s_awvalid, 0);
        chk("rm_m0_wready", m0_wready, 0);
        chk("rm_s_awaddr", s_awaddr, 0);
        set_w(0, 32'h0, 1'b0, 1'b0);
        s_wready = 1'b0;
        tick();
        arst = 1'b1;
        tick();
        aw_through(0, 4'h5, 32'hA00, 4'h0);
        beat(0, 32'h60, 1'b1);
        chk("rm_err_clear", wlast_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axi_wr_arbiter.md
# axi_wr_arbiter

Two-master to one-slave AXI write-path arbiter placed between two master BFMs and the `axi_slave` write channels (AW, W, B). It grants one write burst at a time, registers the winning address phase, and locks the W channel to the granted master until the last beat. It routes each B response back to its originating master through an ID-prefix bit and flags malformed bursts.

## Interface

Parameters:
- `ID_W`, 4: master-side ID width. The slave-side ID is `ID_W+1` bits.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width. The strobe is `DATA_W/8` bits.

Ports:
- `aclk`  in  1  clock; all logic on the rising edge.
- `arst`  in  1  reset, asynchronous assert, active-low.
- `m0_awid/m1_awid`  in  ID_W  master write ID.
- `m0_awaddr/m1_awaddr`  in  ADDR_W  burst address.
- `m0_awlen/m1_awlen`  in  4  beats minus one.
- `m0_awsize/m1_awsize`  in  3; `m0_awburst/m1_awburst`  in  2  passed through unchanged.
- `m0_awvalid/m1_awvalid`  in  1; `m0_awready/m1_awready`  out  1  AW handshake.
- `m0_wdata/m1_wdata`  in  DATA_W; `m0_wstrb/m1_wstrb`  in  DATA_W/8; `m0_wlast/m1_wlast`  in  1.
- `m0_wvalid/m1_wvalid`  in  1; `m0_wready/m1_wready`  out  1  W handshake.
- `m0_bid/m1_bid`  out  ID_W; `m0_bresp/m1_bresp`  out  2; `m0_bvalid/m1_bvalid`  out  1; `m0_bready/m1_bready`  in  1.
- `s_awid`  out  ID_W+1  `{grant_idx, m_awid}`.
- `s_awaddr`, `s_awlen`, `s_awsize`, `s_awburst`  out  the registered AW fields.
- `s_awvalid`  out  1; `s_awready`  in  1.
- `s_wdata`, `s_wstrb`, `s_wlast`, `s_wvalid`  out; `s_wready`  in.
- `s_bid`  in  ID_W+1; `s_bresp`  in  2; `s_bvalid`  in  1; `s_bready`  out  1.
- `wlast_err`  out  1  sticky protocol-error flag; cleared only by reset.

## Operation

FSM states: IDLE, AW, W.

- **IDLE:** when any `mX_awvalid` is high, the arbiter picks the winner. In the same cycle it drives the winner's `mX_awready=1`, latches that master's AW fields, `grant_idx` and `awlen`, then moves to AW. All other `awready` outputs stay 0.
- **AW:** `s_awvalid=1` from the registers. On the `s_awready` handshake the FSM moves to W and clears the beat counter.
- **W:** `s_w*` is a combinational pass-through from the granted master. `s_wready` goes only to the granted master; the other master's `wready=0`.
  - Each handshake increments the 4-bit beat counter.
  - A handshake with `wlast=1` returns the FSM to IDLE.
- **Error:** `wlast_err` sets when `wlast=1` occurs at a count ≠ `awlen`, or when the count reaches `awlen` with `wlast=0`. The burst still ends only on `wlast`.
- **B routing:** independent of the FSM and fully combinational.
  - `s_bid[ID_W]` selects the destination master. `mX_bid = s_bid[ID_W-1:0]`, and `bresp`/`bvalid` are routed the same way.
  - `s_bready` is the selected master's `bready`. The unselected master sees `bvalid=0`.
- Write data presented before the AW grant is held off (`wready=0`).

## Timing

- **Reset values:** every `mX_awready`, `mX_wready` and `mX_bvalid` is 0; `s_awvalid=0`; `s_wvalid=0`; `s_aw*` registers are 0; FSM is IDLE; `last_grant=1` (master 0 wins first); `wlast_err=0`.
- **Latency:** a master AW handshake in cycle N gives `s_awvalid` at N+1. W passthrough and B routing add 0 cycles.
- **Minimum burst occupancy:** 1 (IDLE) + 1 (AW) + awlen+1 cycles. The next grant can occur in the cycle after the final W beat.
- **Handshake holding:** `s_awvalid` is held until `s_awready`, with no deassertion or field change while waiting.
- **Reset mid-burst:** valids drop immediately, the FSM returns to IDLE, and the partial burst is abandoned.
- **B during a new burst:** a B response arriving while another burst is in W is routed normally.

## Configuration

- **`AXI_ARB_RR_EN` defined:** round-robin arbitration. When both masters request in IDLE, the grant goes to the master that is not `last_grant`. `last_grant` updates on each grant.
- **`AXI_ARB_RR_EN` undefined:** fixed priority; master 0 always wins a simultaneous request. `last_grant` is unused.

## Structure

- Package `axi_arb_pkg` holds:
  - the `arb_state_e` enum {IDLE, AW, W};
  - the `m_idx_t` (1-bit) typedef;
  - the `NUM_M=2` constant;
  - `BRESP_OKAY` and `BRESP_SLVERR`.
- Sub-module `axi_rr_arb`: 2-requester grant logic with the `last_grant` register. It contains the `AXI_ARB_RR_EN` switch.

## Test plan

- **Single request:** m0 AW id=3, addr=0x100, len=3, followed by 4 W beats → `s_awid=0x03`, `s_awaddr=0x100`, `s_awvalid` the cycle after the m0 handshake, 4 beats forwarded, FSM back in IDLE, `wlast_err=0`.
- **Simultaneous requests, round-robin build:** m0 and m1 request together twice → grant order m0, m1, m0, m1. In a non-RR build the order is m0, m0, then m1 only after m0 stops requesting.
- **B routing:** slave returns `s_bid=0x15`, `bresp=2` → `m1_bvalid=1`, `m1_bid=0x5`, `m1_bresp=2`, `m0_bvalid=0`. The `s_bready` handshake follows `m1_bready`.
- **Early wlast:** len=3, `wlast=1` on beat 1 → burst ends, `wlast_err=1` and stays set. Missing wlast at beat 3 likewise sets `wlast_err=1`.
- **Early W data:** m1 drives wvalid before its AW grant while m0 holds W → `m1_wready=0` until m1 is granted and the FSM reaches W.
- **Reset mid-burst:** assert `arst=0` during beat 2 of len=7 → `s_wvalid=0` and `s_awvalid=0` immediately; after release a new m0 request is granted normally.
